// File: rtl/axi_lite_xbar_map_ctrl_if.sv
// Bundle between the crossbar map controller and its environment: rule-update
// request/accept, per-port handshake observation and the published rule table.
interface axi_lite_xbar_map_ctrl_if #(
    parameter int unsigned NoSlvPorts = 2,
    parameter int unsigned NoRules    = 4,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned IdxWidth   = 2
) ();
    localparam int unsigned RuleSelWidth = (NoRules > 1) ? unsigned'($clog2(NoRules)) : 1;

    logic                          cfg_valid_i;
    logic                          cfg_ready_o;
    logic [RuleSelWidth-1:0]       cfg_sel_i;
    logic [IdxWidth-1:0]           cfg_idx_i;
    logic [AddrWidth-1:0]          cfg_start_i;
    logic [AddrWidth-1:0]          cfg_end_i;
    logic [NoSlvPorts-1:0]         aw_hs_i;
    logic [NoSlvPorts-1:0]         ar_hs_i;
    logic [NoSlvPorts-1:0]         b_hs_i;
    logic [NoSlvPorts-1:0]         r_hs_i;
    logic                          gate_o;
    logic [NoRules*IdxWidth-1:0]   map_idx_o;
    logic [NoRules*AddrWidth-1:0]  map_start_o;
    logic [NoRules*AddrWidth-1:0]  map_end_o;
    logic                          busy_o;
    logic                          err_o;

    // The controller side.
    modport slave (
        input  cfg_valid_i, cfg_sel_i, cfg_idx_i, cfg_start_i, cfg_end_i,
        input  aw_hs_i, ar_hs_i, b_hs_i, r_hs_i,
        output cfg_ready_o, gate_o, map_idx_o, map_start_o, map_end_o, busy_o, err_o
    );

    // The requester / crossbar side.
    modport master (
        output cfg_valid_i, cfg_sel_i, cfg_idx_i, cfg_start_i, cfg_end_i,
        output aw_hs_i, ar_hs_i, b_hs_i, r_hs_i,
        input  cfg_ready_o, gate_o, map_idx_o, map_start_o, map_end_o, busy_o, err_o
    );
endinterface

// File: rtl/axi_lite_xbar_map_ctrl.sv
// Safe address-map updater for an AXI-Lite crossbar: gates new AW/AR, waits for
// all outstanding writes and reads to drain, then commits one rule.
module axi_lite_xbar_map_ctrl #(
    parameter int unsigned NoSlvPorts = 2,
    parameter int unsigned NoRules    = 4,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned IdxWidth   = 2,
    parameter int unsigned CntWidth   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    axi_lite_xbar_map_ctrl_if.slave  bus
);
    localparam int unsigned RuleSelWidth = (NoRules > 1) ? unsigned'($clog2(NoRules)) : 1;
    localparam int unsigned SumWidth     = CntWidth + unsigned'($clog2(NoSlvPorts)) + 1;
    localparam logic [SumWidth-1:0] CntMax = SumWidth'((64'd1 << CntWidth) - 64'd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [CntWidth-1:0]            wr_cnt_q, wr_cnt_d;
    logic [CntWidth-1:0]            rd_cnt_q, rd_cnt_d;
    logic                           err_q, err_d;
    logic                           wr_flag, rd_flag;
    logic                           sel_ok;
    logic [NoRules*IdxWidth-1:0]    map_idx_q, map_idx_d;
    logic [NoRules*AddrWidth-1:0]   map_start_q, map_start_d;
    logic [NoRules*AddrWidth-1:0]   map_end_q, map_end_d;

    // Net counter update with clamp at 0 and saturation at max; MSB flags either.
    function automatic logic [CntWidth:0] cnt_step(
        input logic [CntWidth-1:0]   cnt,
        input logic [NoSlvPorts-1:0] inc,
        input logic [NoSlvPorts-1:0] dec
    );
        logic [SumWidth-1:0] up;
        logic [SumWidth-1:0] dn;
        logic [SumWidth-1:0] sum;
        up  = SumWidth'(cnt) + SumWidth'($countones(inc));
        dn  = SumWidth'($countones(dec));
        sum = up - dn;
        if (dn > up) begin
            cnt_step = {1'b1, {CntWidth{1'b0}}};
        end else if (sum > CntMax) begin
            cnt_step = {1'b1, {CntWidth{1'b1}}};
        end else begin
            cnt_step = {1'b0, CntWidth'(sum)};
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        map_idx_d   = map_idx_q;
        map_start_d = map_start_q;
        map_end_d   = map_end_q;
        sel_ok      = ({1'b0, bus.cfg_sel_i} < (RuleSelWidth + 1)'(NoRules));

        {wr_flag, wr_cnt_d} = cnt_step(wr_cnt_q, bus.aw_hs_i, bus.b_hs_i);
        {rd_flag, rd_cnt_d} = cnt_step(rd_cnt_q, bus.ar_hs_i, bus.r_hs_i);
        err_d = err_d | wr_flag | rd_flag;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A handshake racing the gate this cycle still has to drain.
                if ((wr_cnt_q == '0) && (rd_cnt_q == '0) &&
                    !(|bus.aw_hs_i) && !(|bus.ar_hs_i)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (!sel_ok) begin
                    err_d = 1'b1;
                end
                for (int unsigned k = 0; k < NoRules; k++) begin
                    if (sel_ok && (bus.cfg_sel_i == RuleSelWidth'(k))) begin
                        map_idx_d[k*IdxWidth +: IdxWidth]     = bus.cfg_idx_i;
                        map_start_d[k*AddrWidth +: AddrWidth] = bus.cfg_start_i;
                        map_end_d[k*AddrWidth +: AddrWidth]   = bus.cfg_end_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_q       <= 1'b0;
            map_idx_q   <= '0;
            map_start_q <= '0;
            map_end_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_q       <= err_d;
            map_idx_q   <= map_idx_d;
            map_start_q <= map_start_d;
            map_end_q   <= map_end_d;
        end
    end

    assign bus.gate_o      = (state_q != IDLE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.cfg_ready_o = (state_q == COMMIT);
    assign bus.err_o       = err_q;
    assign bus.map_idx_o   = map_idx_q;
    assign bus.map_start_o = map_start_q;
    assign bus.map_end_o   = map_end_q;
endmodule

// File: doc/axi_lite_xbar_map_ctrl.md
AXI_LITE_XBAR_MAP_CTRL -- requirements
Module: axi_lite_xbar_map_ctrl

Interface
REQ-001 SHALL have parameter NoSlvPorts, default 2: number of crossbar slave ports observed.
REQ-002 SHALL have parameter NoRules, default 4: number of address-map rules held.
REQ-003 SHALL have parameter AddrWidth, default 32: rule start/end address width.
REQ-004 SHALL have parameter IdxWidth, default 2: rule target master-port index width.
REQ-005 SHALL have parameter CntWidth, default 4: outstanding-transaction counter width.
REQ-006 SHALL have derived parameter RuleSelWidth = max(1, clog2(NoRules)).
REQ-007 SHALL have clk_i  in  1  clock; one clock, all state on the rising edge.
REQ-008 SHALL have rst_i  in  1  reset; synchronous, active-high.
REQ-009 SHALL have cfg_valid_i  in  1  rule-update request.
REQ-010 SHALL have cfg_ready_o  out  1  rule-update accept.
REQ-011 SHALL have cfg_sel_i  in  RuleSelWidth  rule index to write.
REQ-012 SHALL have cfg_idx_i  in  IdxWidth  new target master index.
REQ-013 SHALL have cfg_start_i / cfg_end_i  in  AddrWidth each  new rule address range.
REQ-014 SHALL have aw_hs_i / ar_hs_i  in  NoSlvPorts each  per-port AW/AR handshake pulses.
REQ-015 SHALL have b_hs_i / r_hs_i  in  NoSlvPorts each  per-port B/R handshake pulses.
REQ-016 SHALL have gate_o  out  1  when high, the crossbar blocks new AW/AR on all slave ports.
REQ-017 SHALL have map_idx_o / map_start_o / map_end_o  out  NoRules*IdxWidth, NoRules*AddrWidth, NoRules*AddrWidth  packed rule table; rule k occupies slice k.
REQ-018 SHALL have busy_o  out  1  (state != IDLE).
REQ-019 SHALL have err_o  out  1  sticky counter over/underflow flag.

Function
REQ-020 SHALL implement the states IDLE, DRAIN and COMMIT.
REQ-021 In IDLE with cfg_valid_i=1, SHALL move to DRAIN on the next edge; otherwise it SHALL stay in IDLE.
REQ-022 In DRAIN, SHALL move to COMMIT when the registered wr_cnt==0 and rd_cnt==0, and no aw_hs_i/ar_hs_i bit is set that cycle; otherwise it SHALL stay in DRAIN.
REQ-023 In COMMIT, SHALL move to IDLE unconditionally after one cycle.
REQ-024 SHALL drive gate_o = (state != IDLE) and cfg_ready_o = (state == COMMIT), both decoded from registered state only.
REQ-025 On the COMMIT edge, SHALL write rule cfg_sel_i with cfg_idx_i, cfg_start_i and cfg_end_i; all other rules SHALL be unchanged.
REQ-026 When cfg_sel_i >= NoRules, SHALL perform no write; the handshake still completes and err_o is set.
REQ-027 The requester SHALL hold cfg_valid_i and all cfg_* inputs stable from assertion until cfg_ready_o; the block SHALL never withdraw an issued request.
REQ-028 wr_cnt SHALL update each cycle as wr_cnt + popcount(aw_hs_i) - popcount(b_hs_i), computed at CntWidth+clog2(NoSlvPorts)+1 bits; rd_cnt SHALL use ar_hs_i and r_hs_i in the same way.
REQ-029 Simultaneous increment and decrement SHALL apply as a net change in one cycle.
REQ-030 A result below 0 SHALL clamp to 0 and set err_o; a result above 2^CntWidth-1 SHALL saturate and set err_o.
REQ-031 Counters SHALL count in every state, including handshakes in the IDLE->DRAIN transition cycle (gate not yet high).
REQ-032 Minimum latency, with counters at 0 and the request seen in IDLE at cycle 0: gate_o=1 at cycle 1; cfg_ready_o=1 at cycle 2; new map visible and gate_o=0 at cycle 3.
REQ-033 Back-to-back requests SHALL pass through IDLE for at least one cycle, so each update re-drains.
REQ-034 err_o SHALL clear only on reset.

Reset
REQ-035 On rst_i=1 at an edge, SHALL set state=IDLE, wr_cnt=rd_cnt=0, gate_o=0, cfg_ready_o=0, busy_o=0, err_o=0, and all map_* fields to 0.
REQ-036 Reset asserted in DRAIN or COMMIT SHALL abort the update with no rule written; the requester SHALL re-issue it.

Verification
REQ-037 Idle update: counters 0, cfg_valid_i=1, sel=1, idx=2, start=0x1000, end=0x2000 at cycle 0 -> gate_o 1..2, cfg_ready_o at cycle 2, rule 1 = {2,0x1000,0x2000} at cycle 3, other rules 0.
REQ-038 Drain wait: 2 AW and 1 AR handshakes outstanding, then cfg_valid_i -> gate_o held high; COMMIT only one cycle after the last B and R pulses return wr_cnt and rd_cnt to 0.
REQ-039 Simultaneous events: aw_hs_i=2'b11 and b_hs_i=2'b01 in one cycle from wr_cnt=3 -> wr_cnt=4, err_o=0.
REQ-040 Boundary: b_hs_i pulse with wr_cnt=0 -> wr_cnt stays 0 and err_o=1 (sticky); AW pulses at 15 with CntWidth=4 -> saturates at 15 and err_o=1.
REQ-041 Reset mid-DRAIN: rst_i pulse while in DRAIN with wr_cnt=1 -> next cycle IDLE, gate_o=0, counters 0, map unchanged from reset value 0.
REQ-042 Out-of-range select: NoRules=3, cfg_sel_i=3 -> handshake completes, no rule changes, err_o=1.
